// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage
// Purpose  : Pipeline MEM stage. Holds a DEPTH x 32-bit little-endian data
//            memory with byte/halfword/word loads and stores, a fixed
//            WAIT_STATES access latency with an upstream stall, and the
//            conditional-branch decision (pcsrc).
// Ports    : clk, reset (sync, active-low)
//            intterupt          - blocks acceptance of a new access
//            valid_in           - instruction present in this stage
//            mem_addr/mem_wdata - byte address / right-justified store data
//            mem_read/mem_write - load / store request (both = store)
//            size/load_unsigned - 00 byte, 01 half, 1x word / zero-extend
//            branch/branch_cond/alu_zero/alu_neg - branch evaluation
//            mem_rdata          - registered, extended load data
//            pcsrc              - take branch (combinational)
//            stall              - freeze upstream pipeline
//            done               - one-cycle completion pulse
//            misalign_err       - only with MEM_STAGE_MISALIGN_TRAP_EN
// Config   : MEM_STAGE_MISALIGN_TRAP_EN - misaligned half/word accesses trap
//            instead of being silently aligned.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        intterupt,
    input  logic        valid_in,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic        branch,
    input  logic [1:0]  branch_cond,
    input  logic        alu_zero,
    input  logic        alu_neg,
    output logic [31:0] mem_rdata,
    output logic        pcsrc,
    output logic        stall,
    output logic        done
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam int         AW          = $clog2(DEPTH);
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT      = 2'd1;
    localparam logic [1:0] S_FIN       = 2'd2;
    localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_STATES);
    localparam bit         C_NO_WAIT   = (WAIT_STATES == 0);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_rdata;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [1:0]    r_size;
    logic          r_store;
    logic          r_unsigned;
    logic [31:0]   r_mem [DEPTH];

    // Address bits above the memory window are ignored (wrap-around).
    logic w_unused_addr;
    assign w_unused_addr = &{1'b0, mem_addr[31:AW+2]};

    // ---------------------------------------------------------------- branch
    logic w_cond;
    always_comb begin
        w_cond = 1'b0;
        case (branch_cond)
            2'b00:   w_cond = alu_zero;
            2'b01:   w_cond = !alu_zero;
            2'b10:   w_cond = alu_zero | alu_neg;
            default: w_cond = !alu_zero & !alu_neg;
        endcase
    end
    assign pcsrc = valid_in & branch & w_cond;

    // ------------------------------------------------------------ handshake
    // FIN behaves like IDLE for acceptance so back-to-back accesses lose no cycle.
    logic w_ready, w_accept, w_noacc, w_in_wait, w_do_op;
    assign w_ready   = (r_state == S_IDLE) || (r_state == S_FIN);
    assign w_accept  = w_ready & valid_in & (mem_read | mem_write) & !intterupt;
    assign w_noacc   = w_ready & valid_in & !w_accept;
    assign w_in_wait = (r_state == S_WAIT);
    assign w_do_op   = (w_in_wait && (r_cnt == 4'd1)) || (w_accept && C_NO_WAIT);

    assign stall = w_accept | w_in_wait;
    assign done  = (r_state == S_FIN);

    // Operands come from the live inputs only when the access completes in
    // its acceptance cycle (no wait states); otherwise from the latched copy.
    logic [AW+1:0] w_op_addr;
    logic [31:0]   w_op_wdata;
    logic [1:0]    w_op_size;
    logic          w_op_store, w_op_unsigned;
    assign w_op_addr     = w_in_wait ? r_addr     : mem_addr[AW+1:0];
    assign w_op_wdata    = w_in_wait ? r_wdata    : mem_wdata;
    assign w_op_size     = w_in_wait ? r_size     : size;
    assign w_op_store    = w_in_wait ? r_store    : mem_write;
    assign w_op_unsigned = w_in_wait ? r_unsigned : load_unsigned;

    logic w_blocked;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign w_blocked = ((w_op_size == 2'b01) & w_op_addr[0]) |
                       (w_op_size[1] & (|w_op_addr[1:0]));
`else
    assign w_blocked = 1'b0;
`endif

    // -------------------------------------------------------- lane decoding
    // w_lo is the aligned byte offset: misaligned low bits are dropped.
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lo;
    logic [3:0]    w_be;
    logic [31:0]   w_wlane;
    assign w_idx = w_op_addr[AW+1:2];

    always_comb begin
        w_lo    = 2'b00;
        w_be    = 4'b1111;
        w_wlane = w_op_wdata;
        case (w_op_size)
            2'b00: begin
                w_lo    = w_op_addr[1:0];
                w_be    = 4'b0001 << w_op_addr[1:0];
                w_wlane = {4{w_op_wdata[7:0]}};
            end
            2'b01: begin
                w_lo    = {w_op_addr[1], 1'b0};
                w_be    = w_op_addr[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{w_op_wdata[15:0]}};
            end
            default: begin
                w_lo    = 2'b00;
                w_be    = 4'b1111;
                w_wlane = w_op_wdata;
            end
        endcase
    end

    logic [31:0] w_rshift, w_ldata;
    assign w_rshift = r_mem[w_idx] >> {w_lo, 3'b000};

    always_comb begin
        w_ldata = w_rshift;
        case (w_op_size)
            2'b00:   w_ldata = w_op_unsigned ? {24'd0, w_rshift[7:0]}
                                             : {{24{w_rshift[7]}}, w_rshift[7:0]};
            2'b01:   w_ldata = w_op_unsigned ? {16'd0, w_rshift[15:0]}
                                             : {{16{w_rshift[15]}}, w_rshift[15:0]};
            default: w_ldata = w_rshift;
        endcase
    end

    // --------------------------------------------------------------- memory
    // No reset on the array so it can map to RAM; a reset at the access
    // edge suppresses the write.
    logic w_mem_we;
    assign w_mem_we = reset & w_do_op & w_op_store & !w_blocked;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlane[8*i +: 8];
                end
            end
        end
    end

    // Request snapshot taken at acceptance.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr     <= mem_addr[AW+1:0];
            r_wdata    <= mem_wdata;
            r_size     <= size;
            r_store    <= mem_write;
            r_unsigned <= load_unsigned;
        end
    end

    // ------------------------------------------------------------------ FSM
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic r_mis;
    assign misalign_err = r_mis;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= 32'd0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            r_mis   <= 1'b0;
`endif
        end else begin
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            r_mis <= 1'b0;
`endif
            case (r_state)
                S_IDLE, S_FIN: begin
                    if (w_accept) begin
                        if (C_NO_WAIT) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= C_WAIT_LOAD;
                        end
                    end else if (w_noacc) begin
                        r_state <= S_FIN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd1) begin
                        r_state <= S_FIN;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_do_op) begin
                if (w_blocked) begin
                    r_rdata <= 32'd0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                    r_mis   <= 1'b1;
`endif
                end else if (!w_op_store) begin
                    r_rdata <= w_ldata;
                end
            end
        end
    end

    assign mem_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage
// Purpose  : Self-checking bench for mem_stage. A byte-array memory model
//            predicts load data; directed steps cover the documented cases,
//            followed by randomized accesses and branch evaluations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int DEPTH = 256;
    localparam int WS    = 2;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        intterupt = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [1:0]  size = '0;
    logic        load_unsigned = 1'b0;
    logic        branch = 1'b0;
    logic [1:0]  branch_cond = '0;
    logic        alu_zero = 1'b0;
    logic        alu_neg = 1'b0;
    logic [31:0] mem_rdata;
    logic        pcsrc, stall, done;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int          total = 0;
    int          bad = 0;
    logic [7:0]  mb [4*DEPTH];
    logic [31:0] model_rdata = '0;
    logic [31:0] last_rdata;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk          (clk),
        .reset        (reset),
        .intterupt    (intterupt),
        .valid_in     (valid_in),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .size         (size),
        .load_unsigned(load_unsigned),
        .branch       (branch),
        .branch_cond  (branch_cond),
        .alu_zero     (alu_zero),
        .alu_neg      (alu_neg),
        .mem_rdata    (mem_rdata),
        .pcsrc        (pcsrc),
        .stall        (stall),
        .done         (done)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .misalign_err (misalign_err)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // ----------------------------------------------------------- ref model
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : ((sz == 2'b01) ? 2 : 4);
    endfunction

    function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] sz);
        return (int'(addr % 32'd4) % nbytes(sz)) != 0;
    endfunction

    // First byte touched: address wrapped to the memory size, then aligned.
    function automatic int base_byte(input logic [31:0] addr, input logic [1:0] sz);
        int a;
        a = int'(addr % 32'(4*DEPTH));
        return a - (a % nbytes(sz));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] sz,
                                               input logic uns);
        logic [31:0] v;
        int b, n;
        v = '0;
        b = base_byte(addr, sz);
        n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[b+i];
        if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
        int b;
        b = base_byte(addr, sz);
        for (int i = 0; i < nbytes(sz); i++) mb[b+i] = wd[8*i +: 8];
    endtask

    // ------------------------------------------------------------ drivers
    task automatic idle();
        valid_in  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        intterupt = 1'b0;
        branch    = 1'b0;
    endtask

    task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [1:0] sz, input logic uns,
                          input logic intr, input string tag);
        int stalls, early;
        bit trap;
        @(negedge clk);
        valid_in      = 1'b1;
        mem_read      = rd;
        mem_write     = wr;
        mem_addr      = addr;
        mem_wdata     = wd;
        size          = sz;
        load_unsigned = uns;
        intterupt     = intr;
        branch        = 1'b0;
        if ((rd | wr) && !intr) begin
            stalls = 0;
            early  = 0;
            for (int k = 0; k < WS + 1; k++) begin
                #1;
                if (stall === 1'b1) stalls++;
                if (done !== 1'b0) early++;
                @(negedge clk);
            end
            idle();
            #1;
            trap = TRAP && is_mis(addr, sz);
            if (trap) model_rdata = '0;
            else if (wr) model_store(addr, sz, wd);
            else model_rdata = model_load(addr, sz, uns);
            chk({tag, "/stall_cycles"}, stalls, WS + 1);
            chk({tag, "/done_early"}, early, 0);
            chk({tag, "/done"}, done, 1'b1);
            chk({tag, "/stall_fin"}, stall, 1'b0);
            chk({tag, "/rdata"}, mem_rdata, model_rdata);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            chk({tag, "/misalign"}, misalign_err, trap);
`endif
        end else begin
            #1;
            chk({tag, "/no_stall"}, stall, 1'b0);
            @(negedge clk);
            idle();
            #1;
            chk({tag, "/done"}, done, 1'b1);
            chk({tag, "/rdata_hold"}, mem_rdata, model_rdata);
        end
        last_rdata = mem_rdata;
    endtask

    task automatic br(input logic v, input logic b, input logic [1:0] cond,
                      input logic z, input logic n, input string tag);
        logic c;
        @(negedge clk);
        idle();
        valid_in    = v;
        branch      = b;
        branch_cond = cond;
        alu_zero    = z;
        alu_neg     = n;
        #1;
        case (cond)
            2'b00:   c = z;
            2'b01:   c = !z;
            2'b10:   c = z || n;
            default: c = !z && !n;
        endcase
        chk({tag, "/pcsrc"}, pcsrc, v & b & c);
        chk({tag, "/stall"}, stall, 1'b0);
        @(negedge clk);
        idle();
        #1;
        chk({tag, "/done"}, done, v);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        logic [31:0] a, d;
        logic [1:0]  s;
        int          r;

        // Reset state
        reset = 1'b0;
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("rst/stall", stall, 1'b0);
        chk("rst/done", done, 1'b0);
        chk("rst/rdata", mem_rdata, 32'd0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        chk("rst/misalign", misalign_err, 1'b0);
`endif
        @(negedge clk);
        reset = 1'b1;

        // Word store / load round trip
        access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0, "w_st");
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, "w_ld");
        chk("w_ld/const", last_rdata, 32'hDEAD_BEEF);

        // Byte lane merge and extension
        access(1'b0, 1'b1, 32'h10, 32'h1122_3344, 2'b10, 1'b0, 1'b0, "b_init");
        access(1'b0, 1'b1, 32'h13, 32'h0000_0080, 2'b00, 1'b0, 1'b0, "b_st");
        access(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 1'b0, "b_lds");
        chk("b_lds/const", last_rdata, 32'hFFFF_FF80);
        access(1'b1, 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 1'b0, "b_ldu");
        chk("b_ldu/const", last_rdata, 32'h0000_0080);
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b0, "b_ldw");
        chk("b_ldw/const", last_rdata, 32'h8022_3344);

        // Branch decisions
        br(1'b1, 1'b1, 2'b01, 1'b0, 1'b0, "br_ne");
        br(1'b1, 1'b1, 2'b00, 1'b0, 1'b0, "br_eq");

        // Address wrap, then an interrupted load
        access(1'b0, 1'b1, 32'h400, 32'hA5A5_1234, 2'b10, 1'b0, 1'b0, "wrap_st");
        access(1'b1, 1'b0, 32'h000, 32'h0, 2'b10, 1'b0, 1'b0, "wrap_ld");
        chk("wrap_ld/const", last_rdata, 32'hA5A5_1234);
        access(1'b1, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 1'b1, "intr_ld");
        chk("intr_ld/const", last_rdata, 32'hA5A5_1234);

        // Reset during the wait of a store cancels it
        access(1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 2'b10, 1'b0, 1'b0, "rw_old");
        @(negedge clk);
        valid_in  = 1'b1;
        mem_write = 1'b1;
        mem_read  = 1'b0;
        mem_addr  = 32'h20;
        mem_wdata = 32'hCAFE_F00D;
        size      = 2'b10;
        #1;
        chk("rw/accept_stall", stall, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rw/wait_stall", stall, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        idle();
        #1;
        chk("rw/stall", stall, 1'b0);
        chk("rw/done", done, 1'b0);
        chk("rw/rdata", mem_rdata, 32'd0);
        model_rdata = '0;
        access(1'b1, 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 1'b0, "rw_ld");
        chk("rw_ld/const", last_rdata, 32'h0BAD_F00D);

        // Misaligned halfword
        access(1'b1, 1'b0, 32'h21, 32'h0, 2'b01, 1'b1, 1'b0, "mis_ld");
        chk("mis_ld/const", last_rdata, TRAP ? 32'h0 : 32'h0000_F00D);

        // Fill every word so random loads see defined data
        for (int w = 0; w < DEPTH; w++) begin
            access(1'b0, 1'b1, 32'(w*4), $urandom, 2'b10, 1'b0, 1'b0, "fill");
        end

        // Random accesses
        for (int i = 0; i < 80; i++) begin
            r = int'($urandom_range(0, 9));
            a = $urandom;
            d = $urandom;
            s = 2'($urandom_range(0, 3));
            if (r == 0)
                access(1'b0, 1'b0, a, d, s, 1'($urandom), 1'b0, "rnd_nop");
            else if (r == 1)
                access(1'b1, 1'($urandom), a, d, s, 1'($urandom), 1'b1, "rnd_int");
            else if (r < 5)
                access(1'($urandom), 1'b1, a, d, s, 1'($urandom), 1'b0, "rnd_st");
            else
                access(1'b1, 1'b0, a, d, s, 1'($urandom), 1'b0, "rnd_ld");
        end

        // Random branches
        for (int i = 0; i < 24; i++) begin
            br(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), "rnd_br");
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
